// File: rtl/mem_arbiter.sv
// Two-port round-robin memory arbiter: one req/ack transaction at a time,
// fixed MEM_LAT-cycle access to a single-port memory, registered read data.
module mem_arbiter #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              REQ0,
   input  logic              REQ1,
   input  logic              WE0,
   input  logic              WE1,
   input  logic [ADDR_W-1:0] ADDR0,
   input  logic [ADDR_W-1:0] ADDR1,
   input  logic [WIDTH-1:0]  WDATA0,
   input  logic [WIDTH-1:0]  WDATA1,
   output logic              ACK0,
   output logic              ACK1,
   output logic [WIDTH-1:0]  RDATA,
   output logic              MEM_EN,
   output logic              MEM_WE,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [WIDTH-1:0]  MEM_WDATA,
   input  logic [WIDTH-1:0]  MEM_RDATA,
   output logic              BUSY,
   output logic              GNT_ID
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                last_gnt_q, last_gnt_d;
   logic                gnt_q, gnt_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [WIDTH-1:0]    wdata_q, wdata_d;
   logic [WIDTH-1:0]    rdata_q, rdata_d;
   logic                win;

   // Next-state, operand latch and read capture
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_gnt_d = last_gnt_q;
      gnt_d      = gnt_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      // On a tie the port that did not win last time gets the bus
      win        = (REQ0 && REQ1) ? ~last_gnt_q : REQ1;

      unique case (state_q)
         IDLE: begin
            if (REQ0 || REQ1) begin
               state_d    = ACCESS;
               gnt_d      = win;
               last_gnt_d = win;
               we_d       = win ? WE1 : WE0;
               addr_d     = win ? ADDR1 : ADDR0;
               wdata_d    = win ? WDATA1 : WDATA0;
               cnt_d      = CNT_W'(MEM_LAT - 1);
            end
         end
         ACCESS: begin
            if (cnt_q == '0) begin
               state_d = DONE;
               if (!we_q) rdata_d = MEM_RDATA;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, latched operands and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         last_gnt_q <= 1'b1;
         gnt_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         MEM_EN     <= 1'b0;
         MEM_WE     <= 1'b0;
         BUSY       <= 1'b0;
         ACK0       <= 1'b0;
         ACK1       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_gnt_q <= last_gnt_d;
         gnt_q      <= gnt_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         MEM_EN     <= (state_d == ACCESS);
         MEM_WE     <= (state_d == ACCESS) && we_d;
         BUSY       <= (state_d != IDLE);
         ACK0       <= (state_d == DONE) && !gnt_d;
         ACK1       <= (state_d == DONE) && gnt_d;
      end
   end

   assign MEM_ADDR  = addr_q;
   assign MEM_WDATA = wdata_q;
   assign RDATA     = rdata_q;
   assign GNT_ID    = gnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: MEM_LAT=3 main instance plus a MEM_LAT=1
// instance for the single-cycle read case.
module tb_mem_arbiter;

   localparam int unsigned LAT = 3;

   typedef struct packed {
      logic        we;
      logic [11:0] addr;
      logic [15:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1, we0, we1;
   logic [11:0] addr0, addr1;
   logic [15:0] wdata0, wdata1;
   logic        ack0, ack1, mem_en, mem_we, busy, gnt_id;
   logic [15:0] rdata, mem_wdata, mem_rdata;
   logic [11:0] mem_addr;

   logic        l_req0, l_ack0, l_ack1, l_mem_en, l_mem_we, l_busy, l_gnt_id;
   logic [11:0] l_addr0, l_mem_addr;
   logic [15:0] l_rdata, l_mem_wdata, l_mem_rdata;
   logic        bd_we;
   logic [11:0] bd_a;
   logic [15:0] bd_d;

   logic [15:0] mem  [4096];
   logic [15:0] mem1 [4096];
   logic [15:0] model_mem [4096];

   exp_t        q0[$], q1[$];
   bit          ack_port_log[$];
   int          ack_cyc_log[$];
   logic [15:0] last_rd;
   int          cyc = 0;
   int          we_cyc = 0;
   int          l_ack1_cnt = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   int          t0, a0, a1, l0, l1, w0, base;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_arbiter #(.WIDTH(16), .ADDR_W(12), .MEM_LAT(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .REQ0(req0), .REQ1(req1), .WE0(we0), .WE1(we1),
      .ADDR0(addr0), .ADDR1(addr1), .WDATA0(wdata0), .WDATA1(wdata1),
      .ACK0(ack0), .ACK1(ack1), .RDATA(rdata),
      .MEM_EN(mem_en), .MEM_WE(mem_we), .MEM_ADDR(mem_addr),
      .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata),
      .BUSY(busy), .GNT_ID(gnt_id)
   );

   mem_arbiter #(.WIDTH(16), .ADDR_W(12), .MEM_LAT(1)) u_lat1 (
      .clk(clk), .rst(rst),
      .REQ0(l_req0), .REQ1(1'b0), .WE0(1'b0), .WE1(1'b0),
      .ADDR0(l_addr0), .ADDR1(12'h000), .WDATA0(16'h0000), .WDATA1(16'h0000),
      .ACK0(l_ack0), .ACK1(l_ack1), .RDATA(l_rdata),
      .MEM_EN(l_mem_en), .MEM_WE(l_mem_we), .MEM_ADDR(l_mem_addr),
      .MEM_WDATA(l_mem_wdata), .MEM_RDATA(l_mem_rdata),
      .BUSY(l_busy), .GNT_ID(l_gnt_id)
   );

   // Memory models: synchronous write, combinational read
   always @(posedge clk) if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
   always @(posedge clk) begin
      if (bd_we) mem1[bd_a] <= bd_d;
      else if (l_mem_en && l_mem_we) mem1[l_mem_addr] <= l_mem_wdata;
   end
   assign mem_rdata   = mem[mem_addr];
   assign l_mem_rdata = mem1[l_mem_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every ACK pops the granted port's expected entry
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         q0.delete();
         q1.delete();
         last_rd = '0;
      end else if (ack0 || ack1) begin
         check("ack_onehot", 32'(ack0 & ack1), 32'd0);
         check("gnt_id", 32'(gnt_id), 32'(ack1));
         ack_port_log.push_back(ack1);
         ack_cyc_log.push_back(cyc);
         if ((ack1 && q1.size() == 0) || (!ack1 && q0.size() == 0)) begin
            check("sb_underflow", 32'd1, 32'd0);
         end else begin
            if (ack1) e = q1.pop_front();
            else      e = q0.pop_front();
            if (e.we) check("rdata_hold", 32'(rdata), 32'(last_rd));
            else begin
               check("rdata", 32'(rdata), 32'(e.data));
               last_rd = e.data;
            end
         end
      end
      if (mem_we) we_cyc++;
      if (l_ack1) l_ack1_cnt++;
   end

   // One requester transaction; returns ACK cycle and latency from request
   task automatic txn(input bit p, input bit we, input logic [11:0] a, input logic [15:0] d,
                      input bit mutate, output int ack_c, output int lat);
      exp_t e;
      int   start;
      e.we   = we;
      e.addr = a;
      e.data = we ? d : model_mem[a];
      if (we) model_mem[a] = d;
      start = cyc;
      if (!p) begin q0.push_back(e); we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1; end
      else    begin q1.push_back(e); we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1; end
      ack_c = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (mutate && mem_en) begin
            check("latched_addr", 32'(mem_addr), 32'(a));
            if (!p) addr0 = a ^ 12'h030;
            else    addr1 = a ^ 12'h030;
         end
         if ((!p && ack0) || (p && ack1)) begin
            ack_c = cyc;
            break;
         end
      end
      if (ack_c < 0) check("ack_timeout", 32'd0, 32'd1);
      lat = ack_c - start;
      @(posedge clk);
      #1;
      if (!p) req0 = 1'b0;
      else    req1 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: no finish after 200000 time units");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      {req0, req1, we0, we1, l_req0, bd_we} = '0;
      {addr0, addr1, l_addr0, bd_a} = '0;
      {wdata0, wdata1, bd_d} = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_ack", 32'({ack0, ack1}), 32'd0);
      check("rst_mem_en_we", 32'({mem_en, mem_we}), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      check("rst_busy_gnt", 32'({busy, gnt_id}), 32'd0);

      // Single read with MEM_LAT = 1
      bd_we = 1'b1; bd_a = 12'h005; bd_d = 16'h1234;
      @(negedge clk);
      bd_we = 1'b0;
      l_req0 = 1'b1; l_addr0 = 12'h005; t0 = cyc;
      @(negedge clk);
      check("l1_mem_en", 32'(l_mem_en), 32'd1);
      check("l1_mem_addr", 32'(l_mem_addr), 32'h005);
      check("l1_ack_early", 32'(l_ack0), 32'd0);
      @(negedge clk);
      check("l1_ack", 32'(l_ack0), 32'd1);
      check("l1_ack_cycle", 32'(cyc - t0), 32'd2);
      check("l1_rdata", 32'(l_rdata), 32'h1234);
      check("l1_mem_en_off", 32'(l_mem_en), 32'd0);
      @(posedge clk);
      #1 l_req0 = 1'b0;
      @(negedge clk);
      check("l1_ack_pulse", 32'(l_ack0), 32'd0);
      check("l1_busy_idle", 32'(l_busy), 32'd0);

      // Writes and readbacks, MEM_LAT = 3
      @(posedge clk); #1;
      txn(1'b0, 1'b1, 12'h100, 16'h5A5A, 1'b0, a0, l0);
      check("wr0_latency", 32'(l0), 32'(LAT + 1));
      txn(1'b0, 1'b0, 12'h100, 16'h0000, 1'b0, a0, l0);
      check("rd0_latency", 32'(l0), 32'(LAT + 1));
      w0 = we_cyc;
      txn(1'b1, 1'b1, 12'hFFF, 16'hBEEF, 1'b0, a1, l1);
      check("wr1_we_cycles", 32'(we_cyc - w0), 32'(LAT));
      check("wr1_latency", 32'(l1), 32'(LAT + 1));
      txn(1'b1, 1'b0, 12'hFFF, 16'h0000, 1'b0, a1, l1);

      // Operands are latched at grant
      txn(1'b0, 1'b1, 12'h010, 16'h0A0A, 1'b0, a0, l0);
      txn(1'b0, 1'b0, 12'h010, 16'h0000, 1'b1, a0, l0);

      // Reset in the second ACCESS cycle
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; addr0 = 12'h100;
      base = ack_cyc_log.size();
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_mem_en", 32'(mem_en), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_ack", 32'({ack0, ack1}), 32'd0);
      check("mid_rst_rdata", 32'(rdata), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      txn(1'b0, 1'b0, 12'h100, 16'h0000, 1'b0, a0, l0);
      check("reissue_latency", 32'(l0), 32'(LAT + 1));
      check("mid_rst_ack_count", 32'(ack_cyc_log.size() - base), 32'd1);

      // Simultaneous requests after reset alternate starting with port 0
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      base = ack_port_log.size();
      fork
         begin
            txn(1'b0, 1'b0, 12'h100, 16'h0000, 1'b0, a0, l0);
            txn(1'b0, 1'b0, 12'h010, 16'h0000, 1'b0, a0, l0);
         end
         begin
            txn(1'b1, 1'b0, 12'hFFF, 16'h0000, 1'b0, a1, l1);
            txn(1'b1, 1'b0, 12'h100, 16'h0000, 1'b0, a1, l1);
         end
      join
      check("rr_ack_count", 32'(ack_port_log.size() - base), 32'd4);
      if (ack_port_log.size() >= base + 4) begin
         for (int i = 0; i < 4; i++)
            check("rr_order", 32'(ack_port_log[base+i]), 32'(i % 2));
         for (int i = 1; i < 4; i++)
            check("rr_gap", 32'(ack_cyc_log[base+i] - ack_cyc_log[base+i-1]), 32'(LAT + 2));
      end

      // Late request from port 1 during a port-0 access
      fork
         txn(1'b0, 1'b0, 12'h100, 16'h0000, 1'b0, a0, l0);
         begin
            @(negedge clk);
            @(negedge clk);
            txn(1'b1, 1'b0, 12'h010, 16'h0000, 1'b0, a1, l1);
         end
      join
      check("late_lat0", 32'(l0), 32'(LAT + 1));
      check("late_gap", 32'(a1 - a0), 32'(LAT + 2));

      repeat (3) @(negedge clk);
      check("sb_drained", 32'(q0.size() + q1.size()), 32'd0);
      check("l1_no_ack1", 32'(l_ack1_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter that shares the single-port main memory of the basic computer between the CPU datapath (port 0: fetch, operand and store accesses sequenced by the controller) and an I/O/DMA requester (port 1). It accepts one transaction at a time through a req/ack handshake and drives the memory for a fixed MEM_LAT-cycle access. It returns read data on a registered bus and resolves simultaneous requests round-robin. It sits between the requesters and the memory model, replacing the direct connection from the controller's memory read/write controls.

## Interface
- WIDTH, 16, data word width
- ADDR_W, 12, memory address width (matches the AR width)
- MEM_LAT, 1, memory access cycles per transaction; legal range 1..15
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- REQ0, REQ1  input  1 each  transaction request, held high until the port's ACK
- WE0, WE1  input  1 each  1 = write, 0 = read; valid while REQx is high
- ADDR0, ADDR1  input  ADDR_W each  address; valid while REQx is high
- WDATA0, WDATA1  input  WIDTH each  write data; valid while REQx is high
- ACK0, ACK1  output  1 each  one-cycle completion pulse
- RDATA  output  WIDTH  data from the last completed read; valid during ACK and held afterwards
- MEM_EN  output  1  memory access enable
- MEM_WE  output  1  memory write enable
- MEM_ADDR  output  ADDR_W  memory address
- MEM_WDATA  output  WIDTH  memory write data
- MEM_RDATA  input  WIDTH  memory read data; valid by the end of the last access cycle
- BUSY  output  1  high in the ACCESS and DONE states
- GNT_ID  output  1  port owning the current or last transaction

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If any REQx is high at a clock edge, pick the winner, latch its WE/ADDR/WDATA into the MEM_* registers, load cnt = MEM_LAT − 1, set GNT_ID, and go to ACCESS.
  - With no request, stay in IDLE.
- Arbitration:
  - Only one request high: that port wins.
  - Both high: the port ≠ last_gnt wins.
  - last_gnt updates to the winner at the grant edge.
  - The reset value of last_gnt is 1, so port 0 wins the first tie.
- ACCESS:
  - MEM_EN = 1; MEM_WE = latched WE.
  - MEM_ADDR and MEM_WDATA are stable for all MEM_LAT cycles.
  - cnt decrements each edge.
  - At the edge with cnt == 0: go to DONE, and for a read capture MEM_RDATA into RDATA.
  - A write leaves RDATA unchanged.
- DONE:
  - ACKx = 1 for the granted port only.
  - MEM_EN = MEM_WE = 0.
  - Next state is IDLE unconditionally; no grant is made from DONE.
- Requester rule:
  - Deassert REQx at the edge ending the ACK cycle.
  - REQx still high in IDLE is treated as a new transaction.
- Changes to a requester's ADDR/WE/WDATA after the grant are ignored; the latched copy is used.
- The non-granted port's REQ stays pending; it is never dropped or acknowledged early.
- Counter width is 4 bits. MEM_LAT outside 1..15 is unsupported; the bench does not exercise it.

## Timing
- Reset (asynchronous, any state, including mid-ACCESS):
  - State goes to IDLE; cnt = 0; last_gnt = 1.
  - ACK0 = ACK1 = 0, MEM_EN = MEM_WE = 0, MEM_ADDR = 0, MEM_WDATA = 0, RDATA = 0, BUSY = 0, GNT_ID = 0.
  - An in-flight transaction is abandoned with no ACK; the requester re-issues it.
- Latency: REQ high in IDLE cycle t gives ACCESS in cycles t+1..t+MEM_LAT and ACK in cycle t+MEM_LAT+1. RDATA is valid from that ACK cycle.
- Throughput: one transaction per MEM_LAT+2 cycles per back-to-back stream (the IDLE cycle is mandatory).
- Starvation bound: with both ports requesting continuously, grants alternate 0,1,0,1. A pending port waits at most one other transaction.
- All outputs are registered or decoded from state registers only. There is no combinational path from REQx to ACKx or MEM_*.

## Test plan
- Reset then single read: rst pulse; memory[0x005] = 0x1234; REQ0 = 1, WE0 = 0, ADDR0 = 0x005 with MEM_LAT = 1 -> MEM_EN high for 1 cycle with MEM_ADDR = 0x005; ACK0 in cycle t+2; RDATA = 0x1234; ACK1 never asserts.
- Write then readback on port 1, MEM_LAT = 3: write 0xBEEF to 0xFFF -> MEM_WE high for exactly 3 cycles, ACK1 at t+4, RDATA unchanged; next read of 0xFFF -> RDATA = 0xBEEF.
- Simultaneous requests: REQ0 = REQ1 = 1 held after reset -> grant order 0,1,0,1 (GNT_ID), four ACKs alternating, one IDLE cycle between each pair.
- Latched operands: after the grant, change ADDR0 from 0x010 to 0x020 mid-ACCESS with MEM_LAT = 3 -> MEM_ADDR stays 0x010 for all three cycles.
- Reset mid-operation: assert rst during the 2nd ACCESS cycle with MEM_LAT = 3 -> MEM_EN and BUSY drop immediately (asynchronous), no ACK, RDATA = 0; the re-issued request completes normally.
- Late requester: REQ1 arrives during a port-0 ACCESS -> REQ1 is held pending, granted in the IDLE cycle after ACK0, and ACK1 arrives MEM_LAT+2 cycles after ACK0.
